systolic_writeback: RTL and testbench
=====================================

Name: systolic_writeback

Overview:
- Result-drain engine on the output side of the systolic array.
- After a tile's accumulation completes, it sweeps the array's matrix_index row select and captures each row of accumulator outcomes.
- Each accumulator is requantized (round, shift, optional ReLU, saturate) to DATA_WIDTH and packed into one word per row.
- Rows are written to the output SRAM over a valid/ready write port.

Parameters:
- ARRAY_SIZE, 8, rows/columns of the array; rows drained per tile.
- DATA_WIDTH, 8, width of each requantized output element.
- K_ACCUM_DEPTH, 8, accumulation depth; sets accumulator width.
- OUTCOME_WIDTH, 2*DATA_WIDTH+(K_ACCUM_DEPTH==1?0:clog2(K_ACCUM_DEPTH))+1 (=20), accumulator width; derived, not overridden.
- ADDR_WIDTH, 10, output SRAM address width.

Ports:
- clk  in  1  clock.
- srst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begin draining a tile.
- base_addr  in  ADDR_WIDTH  SRAM address of row 0; latched on start.
- shift  in  5  requant right-shift; latched on start.
- relu_en  in  1  clamp negatives to 0; latched on start.
- matrix_index  out  6  row select to array.
- mul_outcome  in  ARRAY_SIZE*OUTCOME_WIDTH  selected row, signed; column j at bits [j*OUTCOME_WIDTH +: OUTCOME_WIDTH].
- sram_wvalid  out  1  write request.
- sram_wready  in  1  SRAM accepts write.
- sram_waddr  out  ADDR_WIDTH  write address.
- sram_wdata  out  ARRAY_SIZE*DATA_WIDTH  packed row; column 0 in MSBs (column j at bits [(ARRAY_SIZE-1-j)*DATA_WIDTH +: DATA_WIDTH]).
- busy  out  1  high from the cycle after start is accepted until DONE exits.
- done  out  1  one-cycle pulse after last row is written.

Behaviour:
- Reset values: all outputs 0; state IDLE; row counter 0.
- FSM states and transitions:
  - IDLE: start=1 → latch base_addr, shift (clamped to OUTCOME_WIDTH-1 if larger) and relu_en; row=0; → CAP.
  - CAP: matrix_index=row; register mul_outcome into row_buf; → QNT.
  - QNT: requantize all row_buf elements in parallel; register into sram_wdata; sram_waddr=base_addr+row (wraps modulo 2^ADDR_WIDTH); assert sram_wvalid; → WR.
  - WR: hold sram_wvalid, sram_waddr, sram_wdata and matrix_index stable until sram_wready. On the handshake cycle: deassert wvalid; if row==ARRAY_SIZE-1 → DONE, else row++ → CAP.
  - DONE: done=1 for one cycle, busy still 1; → IDLE.
- start is ignored unless state==IDLE.
- matrix_index holds its last value outside CAP; it returns to 0 only on reset.
- Requant per element a (signed, OUTCOME_WIDTH bits); compute in OUTCOME_WIDTH+1 bits, no intermediate overflow:
  - r = shift==0 ? a : (a + (1<<(shift-1))) >>> shift (round half toward +inf).
  - If relu_en and r<0: r=0.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Latency with sram_wready tied 1, start in cycle 0:
  - Row r handshakes in cycle 3r+3.
  - done high in cycle 3*ARRAY_SIZE+1 (=25).
  - Each cycle of wready low adds one cycle.
- Reset mid-operation: next cycle state IDLE, sram_wvalid=0, busy=0, matrix_index=0; no partial completion signalled.
- start in the same cycle as srst: reset wins.

Decomposition:
- Shared package systolic_pkg:
  - OUTCOME_WIDTH derivation function, used by the array and this block so widths cannot diverge.
  - FSM state encoding.
  - Packing-order constants.
- One sub-module systolic_requant: purely combinational, one element; inputs a, shift, relu_en; output DATA_WIDTH result. Instantiated ARRAY_SIZE times.

Test Plan:
- Basic drain: row r all elements = 4r, shift=2, relu_en=0, base_addr=0x100, wready=1 → 8 writes at 0x100..0x107, every byte of row r = r, done in cycle 25, busy cycles 1–25.
- Rounding (shift=2): acc 6→2, 5→1, 7→2, -6→-1, -7→-2; shift=0 passes 3→3.
- Saturation/ReLU (shift=0): 100000→127, -100000→-128; with relu_en=1, -100000→0 and -1→0; shift=31 behaves as shift=19 (524287→1).
- Backpressure: wready=0 for 5 cycles during row 3 WR → wvalid stays 1, waddr/wdata/matrix_index stable, exactly 8 writes, done in cycle 30.
- start pulsed during busy → no restart, no extra writes; base_addr change mid-drain does not affect addresses.
- srst asserted during row 5 WR → next cycle wvalid=0, busy=0, matrix_index=0, no done; a new start then drains all 8 rows from row 0.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array datapath: accumulator width
// derivation, writeback FSM encoding and output row packing order.
package systolic_pkg;

    // Width of the requant shift amount and of the array row select.
    localparam int SHIFT_WIDTH = 5;
    localparam int MIDX_WIDTH  = 6;

    // Output rows place column 0 in the most significant element slot.
    localparam bit PACK_COL0_MSB = 1'b1;

    // Accumulator width: full product, plus growth from summing k_depth terms,
    // plus one guard bit.  Shared so the array and its consumers agree.
    function automatic int outcome_width(input int data_width, input int k_depth);
        return 2 * data_width + ((k_depth == 1) ? 0 : $clog2(k_depth)) + 1;
    endfunction

    // Element slot (counted from the LSB end) that column col occupies in a packed row.
    function automatic int pack_slot(input int col, input int n_cols);
        return PACK_COL0_MSB ? (n_cols - 1 - col) : col;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CAP  = 3'd1,
        ST_QNT  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } wb_state_e;

endpackage

// File: rtl/systolic_requant.sv
// Single-element requantizer: round-half-up right shift, optional ReLU,
// saturation to the signed output width.  Purely combinational.
module systolic_requant
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int OUTCOME_WIDTH = 20
) (
    input  logic signed [OUTCOME_WIDTH-1:0] a,
    input  logic        [SHIFT_WIDTH-1:0]   shift,
    input  logic                            relu_en,
    output logic        [DATA_WIDTH-1:0]    q
);

    // One extra bit keeps the rounding addition free of overflow.
    localparam logic signed [OUTCOME_WIDTH:0] ONE     = {{OUTCOME_WIDTH{1'b0}}, 1'b1};
    localparam logic signed [OUTCOME_WIDTH:0] SAT_MAX =
        {{(OUTCOME_WIDTH - DATA_WIDTH + 2){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [OUTCOME_WIDTH:0] SAT_MIN =
        {{(OUTCOME_WIDTH - DATA_WIDTH + 2){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    logic signed [OUTCOME_WIDTH:0] a_ext;
    logic signed [OUTCOME_WIDTH:0] bias;
    logic signed [OUTCOME_WIDTH:0] sum;
    logic signed [OUTCOME_WIDTH:0] r;

    // Round, shift, clamp negatives when requested, then saturate.
    always_comb begin
        a_ext = {a[OUTCOME_WIDTH-1], a};
        bias  = '0;
        if (shift != '0) begin
            bias = ONE << (shift - SHIFT_WIDTH'(1));
        end
        sum = a_ext + bias;
        r   = sum >>> shift;
        if (relu_en && r[OUTCOME_WIDTH]) begin
            r = '0;
        end
        if (r > SAT_MAX) begin
            q = SAT_MAX[DATA_WIDTH-1:0];
        end else if (r < SAT_MIN) begin
            q = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            q = r[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/systolic_writeback.sv
// Result-drain engine: after a tile completes, walks the array row select,
// captures each accumulator row, requantizes it and writes one packed word
// per row to the output SRAM over a valid/ready port.
module systolic_writeback
    import systolic_pkg::*;
#(
    parameter  int ARRAY_SIZE    = 8,
    parameter  int DATA_WIDTH    = 8,
    parameter  int K_ACCUM_DEPTH = 8,
    parameter  int ADDR_WIDTH    = 10,
    localparam int OUTCOME_WIDTH = outcome_width(DATA_WIDTH, K_ACCUM_DEPTH)
) (
    input  logic                                clk,
    input  logic                                srst,
    input  logic                                start,
    input  logic [ADDR_WIDTH-1:0]               base_addr,
    input  logic [SHIFT_WIDTH-1:0]              shift,
    input  logic                                relu_en,
    output logic [MIDX_WIDTH-1:0]               matrix_index,
    input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
    output logic                                sram_wvalid,
    input  logic                                sram_wready,
    output logic [ADDR_WIDTH-1:0]               sram_waddr,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]    sram_wdata,
    output logic                                busy,
    output logic                                done
);

    localparam logic [SHIFT_WIDTH-1:0] SHIFT_MAX = SHIFT_WIDTH'(OUTCOME_WIDTH - 1);
    localparam logic [MIDX_WIDTH-1:0]  LAST_ROW  = MIDX_WIDTH'(ARRAY_SIZE - 1);

    wb_state_e                          state_reg;
    wb_state_e                          state_next;
    logic [MIDX_WIDTH-1:0]              row_reg;
    logic [MIDX_WIDTH-1:0]              midx_reg;
    logic [ADDR_WIDTH-1:0]              base_reg;
    logic [SHIFT_WIDTH-1:0]             shift_reg;
    logic                               relu_reg;
    logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] row_buf_reg;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0]   wdata_reg;
    logic [ADDR_WIDTH-1:0]              waddr_reg;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0]   q_packed;
    logic [SHIFT_WIDTH-1:0]             shift_clamped;
    logic                               handshake;
    logic                               last_row;

    assign shift_clamped = (shift > SHIFT_MAX) ? SHIFT_MAX : shift;
    assign handshake     = (state_reg == ST_WR) && sram_wready;
    assign last_row      = (row_reg == LAST_ROW);

    // One requantizer per column, each feeding its packed output slot.
    genvar gi;
    generate
        for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_col
            localparam int SLOT = pack_slot(gi, ARRAY_SIZE);
            logic [DATA_WIDTH-1:0] q;

            systolic_requant #(
                .DATA_WIDTH    (DATA_WIDTH),
                .OUTCOME_WIDTH (OUTCOME_WIDTH)
            ) u_requant (
                .a       (row_buf_reg[gi*OUTCOME_WIDTH +: OUTCOME_WIDTH]),
                .shift   (shift_reg),
                .relu_en (relu_reg),
                .q       (q)
            );

            assign q_packed[SLOT*DATA_WIDTH +: DATA_WIDTH] = q;
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: capture, quantize, write each row in turn.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_CAP;
            ST_CAP:  state_next = ST_QNT;
            ST_QNT:  state_next = ST_WR;
            ST_WR:   if (handshake) state_next = last_row ? ST_DONE : ST_CAP;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the current state.
    always_comb begin
        sram_wvalid = (state_reg == ST_WR);
        busy        = (state_reg != ST_IDLE);
        done        = (state_reg == ST_DONE);
    end

    // Datapath: latch tile settings, walk rows, capture and hold write data.
    // The row select is updated on entry to CAP so the array output is valid
    // while CAP samples it, and it holds its value elsewhere.
    always_ff @(posedge clk) begin
        if (srst) begin
            row_reg     <= '0;
            midx_reg    <= '0;
            base_reg    <= '0;
            shift_reg   <= '0;
            relu_reg    <= 1'b0;
            row_buf_reg <= '0;
            wdata_reg   <= '0;
            waddr_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        base_reg  <= base_addr;
                        shift_reg <= shift_clamped;
                        relu_reg  <= relu_en;
                        row_reg   <= '0;
                        midx_reg  <= '0;
                    end
                end
                ST_CAP: begin
                    row_buf_reg <= mul_outcome;
                end
                ST_QNT: begin
                    wdata_reg <= q_packed;
                    waddr_reg <= base_reg + ADDR_WIDTH'(row_reg);
                end
                ST_WR: begin
                    if (sram_wready && !last_row) begin
                        row_reg  <= row_reg + MIDX_WIDTH'(1);
                        midx_reg <= row_reg + MIDX_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign matrix_index = midx_reg;
    assign sram_waddr   = waddr_reg;
    assign sram_wdata   = wdata_reg;

endmodule

// File: tb/tb_systolic_writeback.sv
// Directed bench for systolic_writeback: an array model drives the selected
// row, expected SRAM writes are queued at start and checked on each handshake.
module tb_systolic_writeback;

    localparam int AS = 8;
    localparam int DW = 8;
    localparam int OW = 20;
    localparam int AW = 10;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [AS*DW-1:0] data;
    } wr_t;

    logic                clk = 1'b0;
    logic                srst;
    logic                start;
    logic [AW-1:0]       base_addr;
    logic [4:0]          shift;
    logic                relu_en;
    logic [5:0]          matrix_index;
    logic [AS*OW-1:0]    mul_outcome;
    logic                sram_wvalid;
    logic                sram_wready;
    logic [AW-1:0]       sram_waddr;
    logic [AS*DW-1:0]    sram_wdata;
    logic                busy;
    logic                done;

    int  acc   [AS][AS];
    int  exp_v [AS][AS];
    wr_t sb[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    systolic_writeback #(
        .ARRAY_SIZE    (AS),
        .DATA_WIDTH    (DW),
        .K_ACCUM_DEPTH (8),
        .ADDR_WIDTH    (AW)
    ) dut (
        .clk          (clk),
        .srst         (srst),
        .start        (start),
        .base_addr    (base_addr),
        .shift        (shift),
        .relu_en      (relu_en),
        .matrix_index (matrix_index),
        .mul_outcome  (mul_outcome),
        .sram_wvalid  (sram_wvalid),
        .sram_wready  (sram_wready),
        .sram_waddr   (sram_waddr),
        .sram_wdata   (sram_wdata),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Array model: the selected row of accumulators, combinational on matrix_index.
    always_comb begin
        mul_outcome = '0;
        for (int j = 0; j < AS; j++) begin
            if (matrix_index < 6'(AS)) begin
                mul_outcome[j*OW +: OW] = acc[matrix_index[2:0]][j][OW-1:0];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Reference requant using wide integer arithmetic.
    function automatic int rq(input int a, input int sh, input bit rl);
        int     s;
        longint r;
        s = (sh > OW - 1) ? OW - 1 : sh;
        if (s == 0) r = a;
        else        r = (longint'(a) + (longint'(1) <<< (s - 1))) >>> s;
        if (rl && r < 0) r = 0;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return int'(r);
    endfunction

    function automatic void set_basic();
        for (int r = 0; r < AS; r++)
            for (int j = 0; j < AS; j++)
                acc[r][j] = 4 * r;
    endfunction

    function automatic void fill_exp(input int sh, input bit rl);
        for (int r = 0; r < AS; r++)
            for (int j = 0; j < AS; j++)
                exp_v[r][j] = rq(acc[r][j], sh, rl);
    endfunction

    function automatic logic [AS*DW-1:0] pack_row(input int r);
        logic [AS*DW-1:0] d;
        int               t;
        d = '0;
        for (int j = 0; j < AS; j++) begin
            t = exp_v[r][j];
            d[(AS-1-j)*DW +: DW] = t[DW-1:0];
        end
        return d;
    endfunction

    // Drive one tile and check every cycle until done (or reset injection).
    task automatic run_tile(input string nm, input logic [AW-1:0] ba, input logic [4:0] sh,
                            input logic rl, input int bp_row, input int bp_len,
                            input int rst_row, input bit mid_start, input int exp_done);
        int  k, writes, stalls, done_k, exp_hs;
        bit  fin;
        wr_t w;
        sb.delete();
        for (int r = 0; r < AS; r++) begin
            w.addr = ba + AW'(r);
            w.data = pack_row(r);
            sb.push_back(w);
        end
        @(negedge clk);
        base_addr   = ba;
        shift       = sh;
        relu_en     = rl;
        sram_wready = 1'b1;
        start       = 1'b1;
        @(posedge clk);
        k = 0; writes = 0; stalls = 0; done_k = -1; fin = 1'b0;
        while (!fin && k < 80) begin
            @(negedge clk);
            k++;
            start = mid_start && (k == 8);
            if (mid_start && k == 8) base_addr = 10'h3F0;
            sram_wready = 1'b1;
            if (rst_row >= 0 && sram_wvalid && writes == rst_row) begin
                // Reset in the middle of a write, with a competing start.
                sram_wready = 1'b0;
                srst  = 1'b1;
                start = 1'b1;
                @(negedge clk);
                srst  = 1'b0;
                start = 1'b0;
                #1;
                chk({nm, " rst wvalid"}, 64'(sram_wvalid), 64'd0);
                chk({nm, " rst busy"},   64'(busy),        64'd0);
                chk({nm, " rst midx"},   64'(matrix_index), 64'd0);
                chk({nm, " rst done"},   64'(done),        64'd0);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    #1;
                    chk({nm, " post-rst idle"}, 64'({busy, done, sram_wvalid}), 64'd0);
                end
                $display("%s: reset injected at row %0d, %0d rows written", nm, rst_row, writes);
                fin = 1'b1;
            end else begin
                if (bp_row >= 0 && sram_wvalid && writes == bp_row && stalls < bp_len) begin
                    sram_wready = 1'b0;
                    stalls++;
                end
                #1;
                if (sram_wvalid && !sram_wready && sb.size() > 0) begin
                    chk({nm, " stall waddr"}, 64'(sram_waddr), 64'(sb[0].addr));
                    chk({nm, " stall wdata"}, sram_wdata,      sb[0].data);
                    chk({nm, " stall midx"},  64'(matrix_index), 64'(bp_row));
                end
                chk({nm, " busy"}, 64'(busy), 64'(k <= exp_done));
                chk({nm, " done"}, 64'(done), 64'(k == exp_done));
                if (sram_wvalid && sram_wready) begin
                    if (sb.size() == 0) begin
                        chk({nm, " extra write"}, 64'(writes), 64'(AS - 1));
                    end else begin
                        w = sb.pop_front();
                        exp_hs = 3 * writes + 3 + ((bp_row >= 0 && writes >= bp_row) ? bp_len : 0);
                        chk({nm, " waddr"},    64'(sram_waddr), 64'(w.addr));
                        chk({nm, " wdata"},    sram_wdata,      w.data);
                        chk({nm, " hs cycle"}, 64'(k),          64'(exp_hs));
                        $display("%s: row %0d cycle %0d addr %03h data %016h", nm, writes, k,
                                 sram_waddr, sram_wdata);
                    end
                    writes++;
                end
                if (done) begin
                    done_k = k;
                    fin    = 1'b1;
                end
            end
        end
        if (!fin) chk({nm, " timeout"}, 64'd0, 64'd1);
        if (rst_row < 0) begin
            chk({nm, " write count"}, 64'(writes),   64'(AS));
            chk({nm, " done cycle"},  64'(done_k),   64'(exp_done));
            chk({nm, " sb empty"},    64'(sb.size()), 64'd0);
            @(negedge clk);
            #1;
            chk({nm, " idle after"}, 64'({busy, sram_wvalid, done}), 64'd0);
        end
        sb.delete();
    endtask

    initial begin
        srst = 1'b1; start = 1'b0; base_addr = '0; shift = '0; relu_en = 1'b0;
        sram_wready = 1'b0;
        set_basic();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset wvalid", 64'(sram_wvalid),  64'd0);
        chk("reset busy",   64'(busy),         64'd0);
        chk("reset done",   64'(done),         64'd0);
        chk("reset midx",   64'(matrix_index), 64'd0);
        chk("reset waddr",  64'(sram_waddr),   64'd0);
        chk("reset wdata",  sram_wdata,        64'd0);
        srst = 1'b0;

        // Basic drain: row r holds 4r, shift 2 gives byte r.
        set_basic();
        fill_exp(2, 1'b0);
        for (int r = 0; r < AS; r++)
            for (int j = 0; j < AS; j++)
                exp_v[r][j] = r;
        run_tile("basic", 10'h100, 5'd2, 1'b0, -1, 0, -1, 1'b0, 25);

        // Rounding half toward +inf with shift 2.
        set_basic();
        acc[0] = '{6, 5, 7, -6, -7, 0, 1, 2};
        fill_exp(2, 1'b0);
        exp_v[0] = '{2, 1, 2, -1, -2, 0, 0, 1};
        run_tile("round", 10'h000, 5'd2, 1'b0, -1, 0, -1, 1'b0, 25);

        // Saturation with shift 0 (3 passes through unchanged).
        set_basic();
        acc[0] = '{100000, -100000, 3, -1, 127, 128, -128, -129};
        fill_exp(0, 1'b0);
        exp_v[0] = '{127, -128, 3, -1, 127, 127, -128, -128};
        run_tile("sat", 10'h040, 5'd0, 1'b0, -1, 0, -1, 1'b0, 25);

        // ReLU clamps negatives before saturation.
        fill_exp(0, 1'b1);
        exp_v[0] = '{127, 0, 3, 0, 127, 127, 0, 0};
        run_tile("relu", 10'h080, 5'd0, 1'b1, -1, 0, -1, 1'b0, 25);

        // Oversized shift is clamped to 19.
        set_basic();
        acc[0] = '{524287, -524288, 262144, 262143, 0, -1, 1, -262145};
        fill_exp(31, 1'b0);
        exp_v[0] = '{1, -1, 1, 0, 0, 0, 0, -1};
        run_tile("shift31", 10'h0C0, 5'd31, 1'b0, -1, 0, -1, 1'b0, 25);

        // Backpressure on row 3, with addresses wrapping past 0x3FF.
        set_basic();
        fill_exp(2, 1'b0);
        run_tile("bp", 10'h3FC, 5'd2, 1'b0, 3, 5, -1, 1'b0, 30);

        // start and base_addr disturbed mid-drain.
        run_tile("midstart", 10'h200, 5'd2, 1'b0, -1, 0, -1, 1'b1, 25);

        // Reset during row 5 write, then a clean full drain.
        run_tile("reset", 10'h300, 5'd2, 1'b0, -1, 0, 5, 1'b0, 25);
        run_tile("after", 10'h010, 5'd2, 1'b0, -1, 0, -1, 1'b0, 25);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
